simon_seq_ctrl: RTL and testbench
=================================

# simon_seq_ctrl

Game sequencer for the Simon Says display path. It grows a pseudo-random colour sequence one step per round and plays it back through the VGA block's `en`/`color` inputs with fixed on/off durations. It then checks the player's button presses against the stored sequence and reports win or fail. It sits between the debounced button logic and the VGA pixel generator, and is the only driver of that generator's `en` and `color` inputs.

## Interface
- `MAX_LEN`, 16: rounds needed to win; sequence storage depth.
- `ON_CYCLES`, 25_000_000: clk cycles each colour is shown.
- `OFF_CYCLES`, 12_500_000: blank gap after each shown colour, and pause between rounds.
- `TIMEOUT_CYCLES`, 250_000_000: maximum clk cycles allowed between player presses.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse that begins a new game.
- `btn`  in  4  debounced, synchronised single-cycle press pulses; bit0 red, bit1 green, bit2 blue, bit3 cyan.
- `en`  out  1  1 = VGA shows full-screen `color`; 0 = VGA shows the four-quadrant idle screen.
- `color`  out  2  colour code: 0 red, 1 green, 2 blue, 3 cyan.
- `level`  out  $clog2(MAX_LEN+1)  current sequence length.
- `busy`  out  1  high in every state except IDLE, WIN and FAIL.
- `win`  out  1  held high in WIN.
- `fail`  out  1  held high in FAIL.

## Operation
- The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle from reset. A new colour is taken from `lfsr[1:0]`.
- States and transitions:
  - IDLE: `start` sets len=0 and moves to ADD.
  - ADD (1 cycle): seq[len]=lfsr[1:0]; len++; idx=0; timer=ON_CYCLES-1; moves to SHOW_ON.
  - SHOW_ON: en=1, color=seq[idx]. When timer hits 0, timer=OFF_CYCLES-1 and move to SHOW_OFF.
  - SHOW_OFF: en=0. When timer hits 0:
    - if idx==len-1: idx=0, timer=TIMEOUT_CYCLES-1, move to INPUT;
    - otherwise idx++, timer=ON_CYCLES-1, move to SHOW_ON.
  - INPUT: `btn`==0 is no event. A one-hot `btn` encodes to a code c:
    - c≠seq[idx]: move to FAIL.
    - c==seq[idx] and idx<len-1: idx++, reload timeout timer.
    - c==seq[idx] and idx==len-1: go to WIN if len==MAX_LEN; otherwise timer=OFF_CYCLES-1 and move to PAUSE.
    - Multi-hot `btn`: move to FAIL.
    - Timeout timer reaching 0 with no press: move to FAIL.
  - PAUSE: when timer hits 0, move to ADD.
  - WIN / FAIL: `start` sets len=0 and moves to ADD.
- `start` is ignored while `busy`=1. `btn` is ignored outside INPUT.
- Outputs are decoded from registered state/idx/len only; there is no combinational path from `start`/`btn`. `color`=0 whenever en=0.
- seq storage is a register array of MAX_LEN×2 bits. It needs no reset, because entries are always written before they are read.

## Timing
- Reset state: state IDLE, lfsr=LFSR_SEED, len=0, idx=0, timer=0. Outputs en=0, color=0, level=0, busy=0, win=0, fail=0.
- Sequence from `start`:
  - `start` sampled at edge N puts the block in ADD after N.
  - en rises after edge N+1.
  - level increments after edge N+1.
- en stays high exactly ON_CYCLES cycles per colour. The gap is exactly OFF_CYCLES cycles.
- A press sampled at edge M takes effect after edge M; win/fail rise one cycle after the deciding press.
- Reset asserted mid-game returns to the reset state immediately, with outputs low asynchronously.
- `start` coincident with a `btn` pulse in WIN/FAIL: `start` wins and `btn` is ignored.
- Timers are $clog2(max(ON,OFF,TIMEOUT)) bits wide and down-count to 0 without wrap. idx and len never exceed MAX_LEN.

## Structure
- Package `simon_pkg` holds:
  - the state enum;
  - colour codes COL_RED=0, COL_GRN=1, COL_BLU=2, COL_CYN=3;
  - a `btn_to_code` function that returns the code plus a one-hot-valid flag.
- Sub-module `simon_lfsr` (clk, rst, seed param, 16-bit state out) is reused by future game blocks.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=2, TIMEOUT_CYCLES=20, MAX_LEN=3.
- Reset, then idle for 10 cycles -> en, color, level, busy, win and fail stay 0; `btn` pulses are ignored.
- `start` pulse -> level=1 and en=1 for exactly 4 cycles starting 2 cycles after `start`. The bench records color c0, then sees en=0 for 2 cycles, then INPUT (busy=1, en=0).
- Correct replay each round -> level goes 1→2→3. Round k shows k colours with c0 unchanged. The third correct press in round 3 gives win=1, busy=0, held.
- Wrong one-hot press (code ≠ seq[0]) in round 1 -> fail=1 one cycle later; a later `start` restarts the game at level=1.
- btn=4'b0011 in INPUT -> fail. No press for 20 cycles in INPUT -> fail=1.
- Reset asserted during SHOW_ON -> en drops without waiting for a clock edge; after release all outputs are 0. `start` while busy -> no change to level or sequence.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says game blocks.
// Colour codes, sequencer states and button decoding.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_INPUT,
    S_PAUSE,
    S_WIN,
    S_FAIL
  } state_t;

  localparam logic [1:0] COL_RED = 2'd0;
  localparam logic [1:0] COL_GRN = 2'd1;
  localparam logic [1:0] COL_BLU = 2'd2;
  localparam logic [1:0] COL_CYN = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } btn_code_t;

  function automatic btn_code_t btn_to_code(
    input logic [3:0] btn
  );
    btn_code_t r;
    r.valid = 1'b1;
    r.code  = COL_RED;
    case (btn)
      4'b0001: r.code = COL_RED;
      4'b0010: r.code = COL_GRN;
      4'b0100: r.code = COL_BLU;
      4'b1000: r.code = COL_CYN;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] lfsr_color(
    input logic [15:0] s
  );
    return s[1:0];
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Free-running from reset; seed must be non-zero.
module simon_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  logic fb;

  assign fb = state[15] ^ state[13] ^ state[12] ^ state[10];

  // Advance one step every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEED;
    else      state <= {state[14:0], fb};
  end

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon Says sequencer: grows, shows and checks a colour sequence.
// Drives the VGA block's en/color inputs and reports win/fail.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int          MAX_LEN        = 16,
  parameter int          ON_CYCLES      = 25_000_000,
  parameter int          OFF_CYCLES     = 12_500_000,
  parameter int          TIMEOUT_CYCLES = 250_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [3:0]                   btn,
  output logic                         en,
  output logic [1:0]                   color,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         busy,
  output logic                         win,
  output logic                         fail
);

  localparam int T1   = ON_CYCLES > OFF_CYCLES
                      ? ON_CYCLES : OFF_CYCLES;
  localparam int TMAX = T1 > TIMEOUT_CYCLES
                      ? T1 : TIMEOUT_CYCLES;
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;

  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MX = LW'(MAX_LEN);

  state_t        state, state_n;
  logic [LW-1:0] len, len_n;
  logic [LW-1:0] idx, idx_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   lfsr;
  logic [1:0]    seq [MAX_LEN];
  logic          seq_we;
  logic [1:0]    cur;
  logic          last;
  btn_code_t     bc;

  simon_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign cur  = seq[idx[IW-1:0]];
  assign last = (idx == len - 1'b1);
  assign bc   = btn_to_code(btn);

  // Control state and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      len   <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
      idx   <= idx_n;
      timer <= timer_n;
    end
  end

  // Sequence storage; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (seq_we) seq[len[IW-1:0]] <= lfsr_color(lfsr);
  end

  // Next-state, counter updates and registered-state output decode.
  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    timer_n = (timer != '0) ? timer - 1'b1 : timer;
    seq_we  = 1'b0;
    unique case (state)
      S_IDLE, S_WIN, S_FAIL: begin
        if (start) begin
          len_n   = '0;
          state_n = S_ADD;
        end
      end
      S_ADD: begin
        seq_we  = 1'b1;
        len_n   = len + 1'b1;
        idx_n   = '0;
        timer_n = ON_LD;
        state_n = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer == '0) begin
          timer_n = OFF_LD;
          state_n = S_SHOW_OFF;
        end
      end
      S_SHOW_OFF: begin
        if (timer == '0) begin
          if (last) begin
            idx_n   = '0;
            timer_n = TO_LD;
            state_n = S_INPUT;
          end else begin
            idx_n   = idx + 1'b1;
            timer_n = ON_LD;
            state_n = S_SHOW_ON;
          end
        end
      end
      S_INPUT: begin
        if (btn != 4'b0000) begin
          if (!bc.valid || bc.code != cur) begin
            state_n = S_FAIL;
          end else if (!last) begin
            idx_n   = idx + 1'b1;
            timer_n = TO_LD;
          end else if (len == LEN_MX) begin
            state_n = S_WIN;
          end else begin
            timer_n = OFF_LD;
            state_n = S_PAUSE;
          end
        end else if (timer == '0) begin
          state_n = S_FAIL;
        end
      end
      S_PAUSE: begin
        if (timer == '0) state_n = S_ADD;
      end
      default: state_n = S_IDLE;
    endcase

    en    = (state == S_SHOW_ON);
    color = en ? cur : COL_RED;
    level = len;
    busy  = !(state == S_IDLE || state == S_WIN
              || state == S_FAIL);
    win   = (state == S_WIN);
    fail  = (state == S_FAIL);
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Randomised self-checking bench for simon_seq_ctrl.
// Reference: colour list grown from a behavioural LFSR.
module tb_simon_seq_ctrl;

  localparam int          MAX_LEN = 3;
  localparam int          ON_C    = 4;
  localparam int          OFF_C   = 2;
  localparam int          TO_C    = 20;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       en;
  logic [1:0] color;
  logic [1:0] level;
  logic       busy;
  logic       win;
  logic       fail;

  int checks = 0;
  int errors = 0;

  logic [15:0] m;
  logic [15:0] m_prev;
  logic [1:0]  exp_q [$];

  simon_seq_ctrl #(
    .MAX_LEN        (MAX_LEN),
    .ON_CYCLES      (ON_C),
    .OFF_CYCLES     (OFF_C),
    .TIMEOUT_CYCLES (TO_C),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .btn   (btn),
    .en    (en),
    .color (color),
    .level (level),
    .busy  (busy),
    .win   (win),
    .fail  (fail)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(
    input logic [15:0] s
  );
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m      <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m;
      m      <= step(m);
    end
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'b0000;
  endtask

  task automatic start_game(input logic [3:0] b);
    exp_q.delete();
    start = 1'b1;
    btn   = b;
    tick();
    start = 1'b0;
    btn   = 4'b0000;
    chk("add_en", int'(en), 0);
    chk("add_busy", int'(busy), 1);
    chk("add_level", int'(level), 0);
    tick();
    chk("en_latency", int'(en), 1);
  endtask

  task automatic show_round(input bit poke);
    int n;
    int on;
    int off;
    n = 0;
    while (!en && n < 60) begin
      tick();
      n++;
    end
    chk("en_rise", int'(en), 1);
    if (!en) return;
    exp_q.push_back(m_prev[1:0]);
    chk("level", int'(level), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      on = 0;
      while (en && on < 10) begin
        chk("color", int'(color), int'(exp_q[i]));
        on++;
        if (poke && i == 0 && on == 1) start = 1'b1;
        tick();
        start = 1'b0;
      end
      chk("on_len", on, ON_C);
      if (i < exp_q.size() - 1) begin
        off = 0;
        while (!en && off < 10) begin
          chk("off_color", int'(color), 0);
          off++;
          tick();
        end
        chk("off_len", off, OFF_C);
      end else begin
        chk("gap_en1", int'(en), 0);
        tick();
        chk("gap_en2", int'(en), 0);
        tick();
        chk("input_busy", int'(busy), 1);
        chk("input_en", int'(en), 0);
      end
    end
    chk("level_after", int'(level), exp_q.size());
  endtask

  task automatic replay();
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("no_fail", int'(fail), 0);
      press(4'b0001 << exp_q[i]);
    end
    if (exp_q.size() == MAX_LEN) begin
      chk("win", int'(win), 1);
      chk("win_busy", int'(busy), 0);
    end else begin
      chk("pause_busy", int'(busy), 1);
      chk("pause_win", int'(win), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] w;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      btn = 4'($urandom_range(0, 15));
      tick();
      chk("idle_outs",
          int'({en, color, level, busy, win, fail}), 0);
    end
    btn = 4'b0000;

    start_game(4'b0000);
    for (int r = 1; r <= MAX_LEN; r++) begin
      show_round(r == 2);
      replay();
    end
    press(4'b0001 << $urandom_range(0, 3));
    repeat (4) tick();
    chk("win_held", int'(win), 1);
    chk("win_held_busy", int'(busy), 0);
    chk("win_level", int'(level), MAX_LEN);

    start_game(4'b0000);
    show_round(1'b0);
    w = exp_q[0] + 2'($urandom_range(1, 3));
    chk("pre_fail", int'(fail), 0);
    press(4'b0001 << w);
    chk("wrong_fail", int'(fail), 1);
    chk("wrong_busy", int'(busy), 0);

    start_game(4'b0000);
    show_round(1'b0);
    chk("restart_level", int'(level), 1);
    press(4'b0011);
    chk("multihot_fail", int'(fail), 1);

    start_game(4'b0000);
    show_round(1'b0);
    for (int k = 0; k < TO_C; k++) begin
      chk("to_wait", int'(fail), 0);
      tick();
    end
    chk("timeout_fail", int'(fail), 1);

    start_game(4'b0001 << $urandom_range(0, 3));
    chk("start_over_btn", int'(fail), 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_en", int'(en), 0);
    chk("async_outs",
        int'({en, color, level, busy, win, fail}), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_outs",
        int'({en, color, level, busy, win, fail}), 0);

    repeat ($urandom_range(0, 7)) tick();
    start_game(4'b0000);
    show_round(1'b0);
    replay();
    show_round(1'b0);
    chk("round2_level", int'(level), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
